keypad_scan: RTL

- Input-side counterpart of the multiplexed 7-segment display driver.
- Drives one column of a 4x4 matrix keypad at a time, active-low, and reads the four row lines back.
- Assembles a full-matrix snapshot per scan frame, debounces it, and emits one-cycle key events with a 4-bit code.
- Feeds the game FSM (hero movement, menu select) and runs in the same clk domain as the display.

---
 rtl/keypad_scan.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
//
// Purpose:
//   Scans a 4x4 matrix keypad one column at a time and turns the raw matrix
//   into debounced, one-cycle key events for the game FSM. This is the input
//   counterpart of the multiplexed 7-segment driver and runs in the same clk
//   domain.
//
//   Each column is driven low for SCAN_DIV clocks. The row lines are sampled
//   at the end of the slot, so they have settled for at least SCAN_DIV-2
//   cycles after the 2-FF synchronizer. Four column slots form one frame.
//   Once a frame is complete, it is reduced to a single candidate key: the
//   lowest pressed code, or "none". A key is accepted only after the same
//   candidate is seen in DEBOUNCE consecutive frames. A release is accepted
//   only after DEBOUNCE consecutive empty frames.
//
// Parameters:
//   SCAN_DIV  clocks per column slot (>= 4)
//   DEBOUNCE  identical frames needed to accept a press or release (1..15)
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    column drive, active-low, exactly one bit low
//   key_code   code of the last accepted key (row*4 + col)
//   key_valid  one-cycle pulse when a debounced press is accepted
//   key_held   high while the accepted key is considered pressed
// -----------------------------------------------------------------------------
module keypad_scan #(
    parameter int SCAN_DIV = 1350,
    parameter int DEBOUNCE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);
    localparam logic [3:0]        DEB_MAX  = 4'(DEBOUNCE);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESSED = 1'b1
    } state_t;

    // Active-low drive pattern for a column index.
    function automatic logic [3:0] col_drive(input logic [1:0] c);
        logic [3:0] one_hot;
        one_hot = 4'b0001 << c;
        return ~one_hot;
    endfunction

    // Lowest-index pressed key in a frame, returned as {none, code}.
    // The loop runs from high to low so that the smallest code wins.
    function automatic logic [4:0] first_key(input logic [15:0] f);
        logic [4:0] res;
        res = 5'b1_0000;
        for (int i = 15; i >= 0; i--) begin
            if (f[i]) begin
                res = {1'b0, 4'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- state
    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       col_r;
    logic [15:0]      frame_r;
    logic             eval_r;
    logic             prev_none_r;
    logic [3:0]       prev_code_r;
    logic [3:0]       stab_cnt_r;
    state_t           state_r;

    // ------------------------------------------------------------ combinational
    logic             tick_s;
    logic [15:0]      frame_next_s;
    logic [4:0]       cand_s;
    logic             cand_none_s;
    logic [3:0]       cand_code_s;
    logic             same_s;
    logic [3:0]       cnt_next_s;
    logic             stable_s;

    assign tick_s      = (div_r == DIV_LAST);
    assign cand_s      = first_key(frame_r);
    assign cand_none_s = cand_s[4];
    assign cand_code_s = cand_s[3:0];

    // Two-flop synchronizer for the asynchronous row lines. Its idle value is
    // "nothing pressed".
    always_ff @(posedge clk) begin
        if (rst) begin
            row_meta_r <= 4'b1111;
            row_sync_r <= 4'b1111;
        end else begin
            row_meta_r <= row_in;
            row_sync_r <= row_meta_r;
        end
    end

    // Next frame contents. The buffer is cleared on the evaluation cycle.
    // At the end of a column slot, the four row bits for that column are
    // stored at code positions row*4 + col.
    always_comb begin
        frame_next_s = frame_r;
        if (eval_r) begin
            frame_next_s = 16'h0000;
        end else begin
            frame_next_s = frame_r;
        end
        if (tick_s) begin
            for (int r = 0; r < 4; r++) begin
                frame_next_s[{2'(r), col_r}] = ~row_sync_r[r];
            end
        end else begin
            frame_next_s = frame_next_s;
        end
    end

    // Column divider, column rotation, and frame capture. eval_r flags the
    // cycle right after the column-3 sample, when the frame is complete.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_r   <= '0;
            col_r   <= 2'd0;
            col_out <= 4'b1110;
            frame_r <= 16'h0000;
            eval_r  <= 1'b0;
        end else begin
            frame_r <= frame_next_s;
            eval_r  <= tick_s && (col_r == 2'd3);
            if (tick_s) begin
                div_r   <= '0;
                col_r   <= col_r + 2'd1;
                col_out <= col_drive(col_r + 2'd1);
            end else begin
                div_r   <= div_r + DIV_ONE;
            end
        end
    end

    // Stability bookkeeping: is this frame's candidate the same as the last
    // one? If so, extend the run (saturating); otherwise start a new run at 1.
    // "none" counts as a candidate, so runs of empty frames count too.
    always_comb begin
        same_s = (cand_none_s == prev_none_r) &&
                 (cand_none_s || (cand_code_s == prev_code_r));
        if (same_s) begin
            if (stab_cnt_r >= DEB_MAX) begin
                cnt_next_s = DEB_MAX;
            end else begin
                cnt_next_s = stab_cnt_r + 4'd1;
            end
        end else begin
            cnt_next_s = 4'd1;
        end
        stable_s = (cnt_next_s >= DEB_MAX);
    end

    // Debounce counter and press/release FSM with registered outputs. The FSM
    // acts only on evaluation cycles, so key_valid cannot be high on
    // back-to-back cycles. In PRESSED, a change to another key is tracked by
    // the counter but produces no event. Only a debounced empty run releases.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            stab_cnt_r  <= 4'd0;
            prev_none_r <= 1'b1;
            prev_code_r <= 4'd0;
            key_code    <= 4'd0;
            key_valid   <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (eval_r) begin
                stab_cnt_r  <= cnt_next_s;
                prev_none_r <= cand_none_s;
                prev_code_r <= cand_code_s;
                case (state_r)
                    IDLE: begin
                        if (!cand_none_s && stable_s) begin
                            key_code  <= cand_code_s;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                            state_r   <= PRESSED;
                        end else begin
                            state_r   <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (cand_none_s && stable_s) begin
                            key_held <= 1'b0;
                            state_r  <= IDLE;
                        end else begin
                            state_r  <= PRESSED;
                        end
                    end
                    default: begin
                        key_held <= 1'b0;
                        state_r  <= IDLE;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule
